// File: rtl/fetch_pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
// Exception vector support is compiled in with FETCH_EXC_VECTOR_EN.
package fetch_pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_JUMP = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JR   = 3'd3,
        SEL_EXC  = 3'd4,
        SEL_ERET = 3'd5
    } redir_sel_e;

    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] index);
        return {pc[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_seq_pc_target_calc.sv
// Combinational redirect priority mux: picks the highest-priority redirect and its target.
// With FETCH_EXC_VECTOR_EN, exc_req and eret sit above jump and bypass the stall gate.
module pc_target_calc
    import fetch_pc_seq_pkg::*;
`ifdef FETCH_EXC_VECTOR_EN
#(
    parameter logic [31:0] EXC_PC = DEF_EXC_PC
)
`endif
(
    input  logic        stall,
    input  logic [31:0] id_pc,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        br_en,
    input  logic        br_equal,
    input  logic [31:0] br_off,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
`ifdef FETCH_EXC_VECTOR_EN
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
`endif
    output logic        redirect,
    output logic [31:0] target
);

    redir_sel_e sel;

    always_comb begin
        sel = SEL_NONE;
        if (!stall) begin
            if (j_en)                   sel = SEL_JUMP;
            else if (br_en && br_equal) sel = SEL_BR;
            else if (jr_en)             sel = SEL_JR;
        end
`ifdef FETCH_EXC_VECTOR_EN
        // Later assignments override, so exc_req ends up highest.
        if (eret)    sel = SEL_ERET;
        if (exc_req) sel = SEL_EXC;
`endif
    end

    always_comb begin
        target = 32'h0;
        case (sel)
            SEL_JUMP: target = jump_target(id_pc, j_index);
            SEL_BR:   target = id_pc + 32'd4 + br_off;
            SEL_JR:   target = jr_target;
`ifdef FETCH_EXC_VECTOR_EN
            SEL_EXC:  target = EXC_PC;
            SEL_ERET: target = epc;
`endif
            default:  target = 32'h0;
        endcase
    end

    assign redirect = (sel != SEL_NONE);

endmodule

// File: rtl/fetch_pc_seq.sv
// Fetch-stage PC sequencer: owns the PC, issues one imem request at a time, delivers PC/PC+4.
// Optional exception/eret redirects are enabled by defining FETCH_EXC_VECTOR_EN.
module fetch_pc_seq
    import fetch_pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef FETCH_EXC_VECTOR_EN
    , parameter logic [31:0] EXC_PC = DEF_EXC_PC
`endif
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_EXC_VECTOR_EN
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
`endif
    input  logic        stall,
    input  logic [31:0] id_pc,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        br_en,
    input  logic        br_equal,
    input  logic [31:0] br_off,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         discard_q, discard_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;

    logic         redirect;
    logic [31:0]  target;

    pc_target_calc
`ifdef FETCH_EXC_VECTOR_EN
    #(.EXC_PC(EXC_PC))
`endif
    u_target (
        .stall     (stall),
        .id_pc     (id_pc),
        .j_en      (j_en),
        .j_index   (j_index),
        .br_en     (br_en),
        .br_equal  (br_equal),
        .br_off    (br_off),
        .jr_en     (jr_en),
        .jr_target (jr_target),
`ifdef FETCH_EXC_VECTOR_EN
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
`endif
        .redirect  (redirect),
        .target    (target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            addr_q     <= RESET_PC;
            tgt_q      <= RESET_PC;
            discard_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tgt_q      <= tgt_d;
            discard_q  <= discard_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tgt_d      = tgt_q;
        discard_d  = discard_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            BOOT: begin
                state_d = REQ;
                if (redirect) addr_d = target;
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        addr_d     = target;
                        discard_d  = 1'b0;
                        if_valid_d = 1'b0;
                    end else if (discard_q) begin
                        addr_d     = tgt_q;
                        discard_d  = 1'b0;
                        if_valid_d = 1'b0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = addr_q;
                        addr_d     = addr_q + 32'd4;
                        if (stall) state_d = HOLD;
                    end
                end else begin
                    // imem_addr must stay stable, so a redirect is parked until the ack returns.
                    if_valid_d = 1'b0;
                    if (redirect) begin
                        tgt_d     = target;
                        discard_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) addr_d = target;
                if (!stall) begin
                    state_d    = REQ;
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc_q + 32'd4;

endmodule
